// File: rtl/ocp_arbiter_n.sv
// N-master to 1-slave OCP arbiter with round-robin or fixed-priority selection.
// The grant is held from the command through the response, with an optional response timeout.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef BEN_WIDTH
`define BEN_WIDTH 4
`endif
`ifndef OCP_CMD_IDLE
`define OCP_CMD_IDLE  3'b000
`define OCP_CMD_WRITE 3'b001
`define OCP_CMD_READ  3'b010
`endif
`ifndef OCP_RESP_NULL
`define OCP_RESP_NULL 2'b00
`define OCP_RESP_DVA  2'b01
`define OCP_RESP_FAIL 2'b10
`define OCP_RESP_ERR  2'b11
`endif

module ocp_arbiter_n #(
    parameter int NMASTERS  = 4,
    parameter int PRIO_MODE = 0,
    parameter int TIMEOUT   = 0,
    parameter int CNT_W     = 16
) (
    input  logic                             clk,
    input  logic                             nrst,
    input  logic [NMASTERS*`ADDR_WIDTH-1:0]  i_MAddr,
    input  logic [NMASTERS*3-1:0]            i_MCmd,
    input  logic [NMASTERS*`DATA_WIDTH-1:0]  i_MData,
    input  logic [NMASTERS*`BEN_WIDTH-1:0]   i_MByteEn,
    output logic [NMASTERS-1:0]              o_SCmdAccept,
    output logic [NMASTERS*`DATA_WIDTH-1:0]  o_SData,
    output logic [NMASTERS*2-1:0]            o_SResp,
    output logic [`ADDR_WIDTH-1:0]           o_MAddr,
    output logic [2:0]                       o_MCmd,
    output logic [`DATA_WIDTH-1:0]           o_MData,
    output logic [`BEN_WIDTH-1:0]            o_MByteEn,
    input  logic                             i_SCmdAccept,
    input  logic [`DATA_WIDTH-1:0]           i_SData,
    input  logic [1:0]                       i_SResp,
    output logic [NMASTERS-1:0]              o_grant,
    output logic [1:0]                       o_state
);

    // Handshake: a command is transferred in a CMD cycle where the granted MCmd != IDLE
    // and i_SCmdAccept=1; the transaction completes in the RESP cycle with SResp != NULL.

    localparam int IDX_W = $clog2(NMASTERS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMD  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   gnt_idx, gnt_idx_nxt;
    logic [IDX_W-1:0]   rr_ptr, rr_ptr_nxt;
    logic [IDX_W-1:0]   winner;
    logic [IDX_W-1:0]   ptr_after;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [NMASTERS-1:0] req;
    logic               resp_err;

    always_comb begin
        req = '0;
        for (int k = 0; k < NMASTERS; k++) begin
            req[k] = (i_MCmd[k*3 +: 3] != `OCP_CMD_IDLE);
        end
    end

    // Winner search: from rr_ptr upward with wrap, or from index 0 in priority mode.
    always_comb begin : sel_p
        int   idx;
        logic found;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int i = 0; i < NMASTERS; i++) begin
            if (PRIO_MODE == 0) begin
                idx = (int'(rr_ptr) + i) % NMASTERS;
            end else begin
                idx = i;
            end
            if (!found && req[idx[IDX_W-1:0]]) begin
                found  = 1'b1;
                winner = idx[IDX_W-1:0];
            end
        end
    end

    assign ptr_after = (gnt_idx == IDX_W'(NMASTERS - 1)) ? '0 : gnt_idx + 1'b1;

    always_comb begin
        state_nxt   = state;
        gnt_idx_nxt = gnt_idx;
        rr_ptr_nxt  = rr_ptr;
        cnt_nxt     = cnt;
        resp_err    = 1'b0;
        case (state)
            S_IDLE: begin
                if (|req) begin
                    gnt_idx_nxt = winner;
                    state_nxt   = S_CMD;
                end
            end
            S_CMD: begin
                // A withdrawn command is abandoned even if the slave accepts in the same cycle,
                // because the slave saw only IDLE on o_MCmd.
                if (!req[gnt_idx]) begin
                    state_nxt = S_IDLE;
                end else if (i_SCmdAccept) begin
                    state_nxt = S_RESP;
                    cnt_nxt   = '0;
                end
            end
            S_RESP: begin
                if (i_SResp != `OCP_RESP_NULL) begin
                    state_nxt  = S_IDLE;
                    rr_ptr_nxt = ptr_after;
                end else if (TIMEOUT > 0 && cnt == CNT_W'(TIMEOUT)) begin
                    resp_err   = 1'b1;
                    state_nxt  = S_IDLE;
                    rr_ptr_nxt = ptr_after;
                end else if (TIMEOUT > 0) begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state   <= S_IDLE;
            gnt_idx <= '0;
            rr_ptr  <= '0;
            cnt     <= '0;
        end else begin
            state   <= state_nxt;
            gnt_idx <= gnt_idx_nxt;
            rr_ptr  <= rr_ptr_nxt;
            cnt     <= cnt_nxt;
        end
    end

    always_comb begin
        o_MAddr      = '0;
        o_MCmd       = `OCP_CMD_IDLE;
        o_MData      = '0;
        o_MByteEn    = '0;
        o_SCmdAccept = '0;
        o_SData      = '0;
        o_SResp      = '0;
        case (state)
            S_CMD: begin
                o_MAddr               = i_MAddr[gnt_idx*`ADDR_WIDTH +: `ADDR_WIDTH];
                o_MCmd                = i_MCmd[gnt_idx*3 +: 3];
                o_MData               = i_MData[gnt_idx*`DATA_WIDTH +: `DATA_WIDTH];
                o_MByteEn             = i_MByteEn[gnt_idx*`BEN_WIDTH +: `BEN_WIDTH];
                o_SCmdAccept[gnt_idx] = i_SCmdAccept;
            end
            S_RESP: begin
                if (resp_err) begin
                    o_SResp[gnt_idx*2 +: 2] = `OCP_RESP_ERR;
                end else begin
                    o_SResp[gnt_idx*2 +: 2]                  = i_SResp;
                    o_SData[gnt_idx*`DATA_WIDTH +: `DATA_WIDTH] = i_SData;
                end
            end
            default: ;
        endcase
    end

    assign o_grant = (state == S_IDLE) ? '0 : ({{(NMASTERS-1){1'b0}}, 1'b1} << gnt_idx);
    assign o_state = state;

endmodule

// File: tb/tb_ocp_arbiter_n.sv
// Directed bench for ocp_arbiter_n: one round-robin instance (TIMEOUT=8) and one fixed-priority instance,
// with expected grants, routing, timeout and reset behaviour computed by hand.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef BEN_WIDTH
`define BEN_WIDTH 4
`endif
`ifndef OCP_CMD_IDLE
`define OCP_CMD_IDLE  3'b000
`define OCP_CMD_WRITE 3'b001
`define OCP_CMD_READ  3'b010
`endif
`ifndef OCP_RESP_NULL
`define OCP_RESP_NULL 2'b00
`define OCP_RESP_DVA  2'b01
`define OCP_RESP_FAIL 2'b10
`define OCP_RESP_ERR  2'b11
`endif

module tb_ocp_arbiter_n;

    logic         clk = 1'b0;
    logic         nrst;
    logic [127:0] m_addr;
    logic [11:0]  m_cmd;
    logic [127:0] m_data;
    logic [15:0]  m_ben;
    logic         s_acc;
    logic [31:0]  s_data;
    logic [1:0]   s_resp;

    logic [3:0]   rr_acc, fp_acc, ob_acc;
    logic [127:0] rr_sdata, fp_sdata, ob_sdata;
    logic [7:0]   rr_sresp, fp_sresp, ob_sresp;
    logic [31:0]  rr_maddr, fp_maddr, ob_maddr;
    logic [2:0]   rr_mcmd, fp_mcmd, ob_mcmd;
    logic [31:0]  rr_mdata, fp_mdata, ob_mdata;
    logic [3:0]   rr_mben, fp_mben, ob_mben;
    logic [3:0]   rr_grant, fp_grant, ob_grant;
    logic [1:0]   rr_state, fp_state, ob_state;
    logic         use_fp = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ocp_arbiter_n #(.NMASTERS(4), .PRIO_MODE(0), .TIMEOUT(8), .CNT_W(16)) dut_rr (
        .clk(clk), .nrst(nrst),
        .i_MAddr(m_addr), .i_MCmd(m_cmd), .i_MData(m_data), .i_MByteEn(m_ben),
        .o_SCmdAccept(rr_acc), .o_SData(rr_sdata), .o_SResp(rr_sresp),
        .o_MAddr(rr_maddr), .o_MCmd(rr_mcmd), .o_MData(rr_mdata), .o_MByteEn(rr_mben),
        .i_SCmdAccept(s_acc), .i_SData(s_data), .i_SResp(s_resp),
        .o_grant(rr_grant), .o_state(rr_state)
    );

    ocp_arbiter_n #(.NMASTERS(4), .PRIO_MODE(1), .TIMEOUT(0), .CNT_W(16)) dut_fp (
        .clk(clk), .nrst(nrst),
        .i_MAddr(m_addr), .i_MCmd(m_cmd), .i_MData(m_data), .i_MByteEn(m_ben),
        .o_SCmdAccept(fp_acc), .o_SData(fp_sdata), .o_SResp(fp_sresp),
        .o_MAddr(fp_maddr), .o_MCmd(fp_mcmd), .o_MData(fp_mdata), .o_MByteEn(fp_mben),
        .i_SCmdAccept(s_acc), .i_SData(s_data), .i_SResp(s_resp),
        .o_grant(fp_grant), .o_state(fp_state)
    );

    assign ob_acc   = use_fp ? fp_acc   : rr_acc;
    assign ob_sdata = use_fp ? fp_sdata : rr_sdata;
    assign ob_sresp = use_fp ? fp_sresp : rr_sresp;
    assign ob_maddr = use_fp ? fp_maddr : rr_maddr;
    assign ob_mcmd  = use_fp ? fp_mcmd  : rr_mcmd;
    assign ob_mdata = use_fp ? fp_mdata : rr_mdata;
    assign ob_mben  = use_fp ? fp_mben  : rr_mben;
    assign ob_grant = use_fp ? fp_grant : rr_grant;
    assign ob_state = use_fp ? fp_state : rr_state;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] onehot(input int g);
        logic [3:0] one;
        one = 4'b0001;
        return one << g;
    endfunction

    task automatic set_master(input int k, input logic [2:0] cmd, input logic [31:0] addr,
                              input logic [31:0] data);
        m_cmd[k*3 +: 3]   = cmd;
        m_addr[k*32 +: 32] = addr;
        m_data[k*32 +: 32] = data;
        m_ben[k*4 +: 4]   = 4'(k + 3);
    endtask

    task automatic do_reset();
        nrst   = 1'b0;
        m_cmd  = '0;
        m_addr = '0;
        m_data = '0;
        m_ben  = '0;
        s_acc  = 1'b0;
        s_data = '0;
        s_resp = `OCP_RESP_NULL;
        repeat (2) @(posedge clk);
        #1 nrst = 1'b1;
        @(negedge clk);
    endtask

    // Entered in an IDLE cycle before its sampling edge; returns in the following IDLE cycle.
    task automatic serve(input int g, input int acc_delay, input logic [31:0] rdata,
                         input bit keep, input string tag);
        logic [2:0]  cmd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  ben;
        cmd   = m_cmd[g*3 +: 3];
        addr  = m_addr[g*32 +: 32];
        wdata = m_data[g*32 +: 32];
        ben   = m_ben[g*4 +: 4];
        @(posedge clk); #1;
        for (int i = 0; i <= acc_delay; i++) begin
            s_acc = (i == acc_delay);
            @(negedge clk);
            check_eq({tag, "/grant"}, ob_grant, onehot(g));
            check_eq({tag, "/mcmd"}, ob_mcmd, cmd);
            check_eq({tag, "/maddr"}, ob_maddr, addr);
            check_eq({tag, "/mdata"}, ob_mdata, wdata);
            check_eq({tag, "/mben"}, ob_mben, ben);
            check_eq({tag, "/acc"}, ob_acc, (i == acc_delay) ? onehot(g) : 4'b0000);
            @(posedge clk); #1;
        end
        s_acc = 1'b0;
        if (!keep) m_cmd[g*3 +: 3] = `OCP_CMD_IDLE;
        s_resp = `OCP_RESP_DVA;
        s_data = rdata;
        @(negedge clk);
        check_eq({tag, "/resp_mcmd"}, ob_mcmd, `OCP_CMD_IDLE);
        check_eq({tag, "/sresp"}, ob_sresp, 128'(2'b01) << (2*g));
        check_eq({tag, "/sdata"}, ob_sdata, 128'(rdata) << (32*g));
        @(posedge clk); #1;
        s_resp = `OCP_RESP_NULL;
        s_data = '0;
        @(negedge clk);
        check_eq({tag, "/idle_grant"}, ob_grant, 4'b0000);
    endtask

    initial begin
        #400000;
        n_errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        // Reset values
        do_reset();
        nrst = 1'b0;
        #1;
        check_eq("rst/grant", rr_grant, 4'b0000);
        check_eq("rst/state", rr_state, 2'd0);
        check_eq("rst/mcmd", rr_mcmd, `OCP_CMD_IDLE);
        check_eq("rst/sresp", rr_sresp, 8'h00);
        check_eq("rst/acc", rr_acc, 4'b0000);
        check_eq("rst/maddr", rr_maddr, 32'h0);
        do_reset();

        // Single read from master 2
        set_master(2, `OCP_CMD_READ, 32'h0000_0004, 32'h0);
        serve(2, 0, 32'hf1f2_f3f4, 1'b0, "rd2");

        // Round-robin over all four writers, pointer starting at 0
        do_reset();
        for (int k = 0; k < 4; k++) set_master(k, `OCP_CMD_WRITE, 32'h100 + 32'(k*4), 32'hA000 + 32'(k));
        serve(0, 0, 32'h0, 1'b0, "rr0");
        serve(1, 0, 32'h0, 1'b0, "rr1");
        serve(2, 0, 32'h0, 1'b0, "rr2");
        serve(3, 0, 32'h0, 1'b0, "rr3");
        for (int k = 0; k < 4; k++) set_master(k, `OCP_CMD_WRITE, 32'h200 + 32'(k*4), 32'hB000 + 32'(k));
        serve(0, 0, 32'h0, 1'b0, "rr2_0");
        serve(1, 0, 32'h0, 1'b0, "rr2_1");
        // Pointer is now 2: with only 1 and 3 requesting, 3 comes first
        set_master(2, `OCP_CMD_IDLE, 32'h0, 32'h0);
        set_master(1, `OCP_CMD_WRITE, 32'h300, 32'hC001);
        serve(3, 0, 32'h0, 1'b0, "rr_3first");
        serve(1, 0, 32'h0, 1'b0, "rr_1after");

        // Slave accepts on the third CMD cycle
        set_master(2, `OCP_CMD_READ, 32'h0000_0040, 32'h0);
        serve(2, 2, 32'h1234_5678, 1'b0, "acc3");

        // Timeout: master 0 granted (pointer 3, master 3 idle), slave never responds
        set_master(0, `OCP_CMD_READ, 32'h500, 32'h0);
        set_master(1, `OCP_CMD_READ, 32'h504, 32'h0);
        @(posedge clk); #1;
        s_acc = 1'b1;
        @(negedge clk);
        check_eq("to/grant", rr_grant, 4'b0001);
        check_eq("to/acc", rr_acc, 4'b0001);
        @(posedge clk); #1;
        s_acc = 1'b0;
        set_master(0, `OCP_CMD_IDLE, 32'h0, 32'h0);
        // Eight silent RESP cycles, then ERR
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_eq($sformatf("to/wait%0d_sresp", i), rr_sresp, 8'h00);
            check_eq($sformatf("to/wait%0d_state", i), rr_state, 2'd2);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check_eq("to/err_sresp", rr_sresp, 8'b0000_0011);
        check_eq("to/err_sdata", rr_sdata, 128'h0);
        @(posedge clk); #1;
        s_resp = `OCP_RESP_DVA;
        s_data = 32'hdead_beef;
        @(negedge clk);
        check_eq("to/idle_state", rr_state, 2'd0);
        check_eq("to/stray_idle_sresp", rr_sresp, 8'h00);
        check_eq("to/stray_idle_sdata", rr_sdata, 128'h0);
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("to/next_grant", rr_grant, 4'b0010);
        check_eq("to/stray_cmd_sresp", rr_sresp, 8'h00);
        check_eq("to/stray_cmd_sdata", rr_sdata, 128'h0);
        @(posedge clk); #1;
        s_resp = `OCP_RESP_NULL;
        s_data = '0;
        s_acc  = 1'b1;
        @(negedge clk);
        check_eq("to/m1_acc", rr_acc, 4'b0010);
        @(posedge clk); #1;
        s_acc = 1'b0;
        set_master(1, `OCP_CMD_IDLE, 32'h0, 32'h0);
        s_resp = `OCP_RESP_DVA;
        s_data = 32'h0bad_f00d;
        @(negedge clk);
        check_eq("to/m1_sresp", rr_sresp, 8'b0000_0100);
        check_eq("to/m1_sdata", rr_sdata, 128'h0bad_f00d << 32);
        @(posedge clk); #1;
        s_resp = `OCP_RESP_NULL;
        s_data = '0;
        @(negedge clk);

        // Reset while in RESP; pointer is 2 beforehand
        set_master(2, `OCP_CMD_READ, 32'h80, 32'h0);
        @(posedge clk); #1;
        s_acc = 1'b1;
        @(posedge clk); #1;
        s_acc = 1'b0;
        s_resp = `OCP_RESP_DVA;
        s_data = 32'haaaa_5555;
        #1;
        check_eq("mid/state_resp", rr_state, 2'd2);
        nrst = 1'b0;
        #1;
        check_eq("mid/grant", rr_grant, 4'b0000);
        check_eq("mid/state", rr_state, 2'd0);
        check_eq("mid/sresp", rr_sresp, 8'h00);
        check_eq("mid/sdata", rr_sdata, 128'h0);
        check_eq("mid/acc", rr_acc, 4'b0000);
        check_eq("mid/mcmd", rr_mcmd, `OCP_CMD_IDLE);
        set_master(2, `OCP_CMD_IDLE, 32'h0, 32'h0);
        s_resp = `OCP_RESP_NULL;
        s_data = '0;
        set_master(0, `OCP_CMD_WRITE, 32'h600, 32'h6);
        set_master(3, `OCP_CMD_WRITE, 32'h60c, 32'h9);
        @(posedge clk); #1;
        nrst = 1'b1;
        @(negedge clk);
        serve(0, 0, 32'h0, 1'b0, "post_rst0");
        serve(3, 0, 32'h0, 1'b0, "post_rst3");

        // Fixed priority: master 1 wins while it keeps requesting
        do_reset();
        use_fp = 1'b1;
        set_master(1, `OCP_CMD_READ, 32'h700, 32'h0);
        set_master(3, `OCP_CMD_READ, 32'h70c, 32'h0);
        serve(1, 0, 32'h11, 1'b1, "fp1_a");
        serve(1, 0, 32'h12, 1'b1, "fp1_b");
        serve(1, 1, 32'h13, 1'b0, "fp1_c");
        serve(3, 0, 32'h33, 1'b0, "fp3");
        use_fp = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
